// File: rtl/dm_pkg.sv
// Shared encodings and lane-enable decode for the big-endian data memory.
// Lane bit 3 is byte offset 0, which lives in data bits [31:24].
package dm_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        WAIT,
        RESP
    } dm_state_e;

    typedef struct packed {
        logic [3:0] lane_en;
        logic       err;
    } dm_lane_t;

    function automatic dm_lane_t dm_lanes(input logic [1:0] size, input logic [1:0] off);
        dm_lane_t r;
        r.lane_en = 4'b0000;
        r.err     = 1'b0;
        case (size)
            SIZE_BYTE: r.lane_en = 4'b1000 >> off;
            SIZE_HALF: begin
                if (off[0]) begin
                    r.err = 1'b1;
                end else begin
                    r.lane_en = off[1] ? 4'b0011 : 4'b1100;
                end
            end
            SIZE_WORD: begin
                if (off != 2'd0) begin
                    r.err = 1'b1;
                end else begin
                    r.lane_en = 4'b1111;
                end
            end
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_byte_ram.sv
// Word-organised RAM with four independent byte lanes; write and read both
// happen on the same edge and the read returns the pre-write contents.
module dm_byte_ram #(
    parameter int WORDS = 64,
    localparam int AW = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic          re,
    output logic [31:0]   rdata
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [WORDS];
            logic [7:0] lane_rd_q;

            always_ff @(posedge clk) begin
                if (we && be[gi]) begin
                    lane_mem[addr] <= wdata[gi*8 +: 8];
                end
                if (re) begin
                    lane_rd_q <= lane_mem[addr];
                end
            end

            assign rdata[gi*8 +: 8] = lane_rd_q;
        end
    endgenerate

endmodule

// File: rtl/data_memory_ctrl.sv
// MEM-stage data memory: valid/ready requests, big-endian byte/half/word
// access, fixed response latency and an optional zeroing pass after reset.
module data_memory_ctrl
    import dm_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int LATENCY        = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_error,
    output logic              init_done
);

    localparam int WA    = ADDR_W - 2;
    localparam int WORDS = 2 ** WA;
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    dm_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WA-1:0]    clr_idx_q, clr_idx_d;
    logic             init_done_q, init_done_d;
    logic [1:0]       size_q, size_d;
    logic [1:0]       off_q, off_d;
    logic             write_q, write_d;
    logic             err_q, err_d;

    dm_lane_t         lanes;
    logic             accept;

    logic             ram_we;
    logic [3:0]       ram_be;
    logic [WA-1:0]    ram_addr;
    logic [31:0]      ram_wdata;
    logic             ram_re;
    logic [31:0]      ram_rdata;
    logic [31:0]      byte_sh;
    logic [31:0]      half_sh;
    logic [31:0]      load_data;

    assign lanes     = dm_lanes(req_size, req_addr[1:0]);
    // Reset masks acceptance so a request coinciding with reset is ignored.
    assign req_ready = (state_q == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= CLEAR_ON_RESET ? CLEAR : IDLE;
            cnt_q       <= '0;
            clr_idx_q   <= '0;
            init_done_q <= !CLEAR_ON_RESET;
            size_q      <= '0;
            off_q       <= '0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clr_idx_q   <= clr_idx_d;
            init_done_q <= init_done_d;
            size_q      <= size_d;
            off_q       <= off_d;
            write_q     <= write_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clr_idx_d   = clr_idx_q;
        init_done_d = init_done_q;
        size_d      = size_q;
        off_d       = off_q;
        write_d     = write_q;
        err_d       = err_q;
        case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + WA'(1);
                if (&clr_idx_q) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end
            end
            IDLE: begin
                if (accept) begin
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                    size_d  = req_size;
                    off_d   = req_addr[1:0];
                    write_d = req_write;
                    err_d   = lanes.err;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0) begin
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Byte offset k sits at bits [31-8k -: 8], so shifting by 8*(3-k) right-justifies it.
    assign byte_sh = ram_rdata >> {~off_q, 3'b000};
    assign half_sh = ram_rdata >> {~off_q[1], 4'b0000};

    always_comb begin
        ram_we    = 1'b0;
        ram_be    = 4'b0000;
        ram_addr  = req_addr[ADDR_W-1:2];
        ram_wdata = 32'h0;
        ram_re    = accept && !req_write;
        if (state_q == CLEAR && !reset) begin
            ram_we   = 1'b1;
            ram_be   = 4'b1111;
            ram_addr = clr_idx_q;
        end else if (accept && req_write && !lanes.err) begin
            ram_we = 1'b1;
            ram_be = lanes.lane_en;
            case (req_size)
                SIZE_BYTE: ram_wdata = {4{req_wdata[7:0]}};
                SIZE_HALF: ram_wdata = {2{req_wdata[15:0]}};
                default:   ram_wdata = req_wdata;
            endcase
        end

        case (size_q)
            SIZE_BYTE: load_data = {24'h0, byte_sh[7:0]};
            SIZE_HALF: load_data = {16'h0, half_sh[15:0]};
            default:   load_data = ram_rdata;
        endcase

        resp_valid = (state_q == RESP) && !reset;
        resp_error = resp_valid && err_q;
        resp_rdata = (resp_valid && !write_q && !err_q) ? load_data : 32'h0;
        init_done  = init_done_q && !reset;
    end

    dm_byte_ram #(
        .WORDS(WORDS)
    ) u_ram (
        .clk  (clock),
        .we   (ram_we),
        .be   (ram_be),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .re   (ram_re),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench: DUT A (LATENCY=3, clearing) and DUT B (LATENCY=1, no clear).
module tb_data_memory_ctrl;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_R = 2'd3;
    localparam int LAT_A = 3;
    localparam int LAT_B = 1;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic [1:0]  rst = 2'b11;
    logic [1:0]  vld = 2'b00;
    logic [1:0]  wr  = 2'b00;
    logic [1:0]  sz   [2];
    logic [7:0]  addr [2];
    logic [31:0] wd   [2];
    logic [1:0]  rdy, rv, er, idn;
    logic [31:0] rd   [2];
    logic [1:0]  prev_rv = 2'b00;

    exp_t q0[$];
    exp_t q1[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_ctrl #(.ADDR_W(8), .LATENCY(LAT_A), .CLEAR_ON_RESET(1'b1)) dut_a (
        .clock(clk), .reset(rst[0]), .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_write(wr[0]), .req_size(sz[0]), .req_addr(addr[0]), .req_wdata(wd[0]),
        .resp_valid(rv[0]), .resp_rdata(rd[0]), .resp_error(er[0]), .init_done(idn[0])
    );

    data_memory_ctrl #(.ADDR_W(8), .LATENCY(LAT_B), .CLEAR_ON_RESET(1'b0)) dut_b (
        .clock(clk), .reset(rst[1]), .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_write(wr[1]), .req_size(sz[1]), .req_addr(addr[1]), .req_wdata(wd[1]),
        .resp_valid(rv[1]), .resp_rdata(rd[1]), .resp_error(er[1]), .init_done(idn[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end else begin
            $display("ok   %s: %08h", name, act);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event did not occur within bound", name);
    endtask

    task automatic check_resp(input int d, input exp_t e);
        chk($sformatf("dut%0d resp_rdata", d), rd[d], e.rdata);
        chk($sformatf("dut%0d resp_error", d), {31'b0, er[d]}, {31'b0, e.err});
        chk($sformatf("dut%0d resp_cycle", d), cyc, e.cyc);
    endtask

    // Monitor: pops an expectation whenever a DUT strobes resp_valid.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rv[d]) begin
                if (d == 0 && q0.size() != 0) check_resp(0, q0.pop_front());
                else if (d == 1 && q1.size() != 0) check_resp(1, q1.pop_front());
                else begin
                    vectors++;
                    miscompares++;
                    $display("FAIL dut%0d unexpected_resp: got resp_valid=1, expected none", d);
                end
            end else if (prev_rv[d]) begin
                chk($sformatf("dut%0d rdata_after_resp", d), rd[d], 32'h0);
                chk($sformatf("dut%0d error_after_resp", d), {31'b0, er[d]}, 32'h0);
            end
            prev_rv[d] = rv[d];
        end
    end

    task automatic issue(input int d, input bit w, input logic [1:0] s, input logic [7:0] a,
                         input logic [31:0] wdat, input logic [31:0] exp_rd, input bit exp_er);
        int   n;
        int   lat;
        exp_t e;
        lat = (d == 0) ? LAT_A : LAT_B;
        n = 0;
        @(negedge clk);
        while (!rdy[d] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[d]) begin
            fail_now($sformatf("dut%0d ready_timeout", d));
            return;
        end
        vld[d] = 1'b1; wr[d] = w; sz[d] = s; addr[d] = a; wd[d] = wdat;
        e.rdata = exp_rd; e.err = exp_er; e.cyc = cyc + lat;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        @(posedge clk);
        #1;
        vld[d] = 1'b0; wr[d] = ~w; sz[d] = ~s; addr[d] = ~a; wd[d] = ~wdat;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            chk($sformatf("dut%0d ready_low_T+%0d", d, k), {31'b0, rdy[d]}, 32'h0);
        end
        @(negedge clk);
        chk($sformatf("dut%0d ready_back", d), {31'b0, rdy[d]}, 32'h1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0) fail_now("drain_responses");
    endtask

    task automatic wait_clear(input string name, output int n, output int seen_rv);
        n = 0;
        seen_rv = 0;
        while (!idn[0] && n < 200) begin
            @(negedge clk);
            n++;
            if (rv[0]) seen_rv++;
            if (n == 32) chk({name, " ready_during_clear"}, {31'b0, rdy[0]}, 32'h0);
        end
        chk({name, " clear_cycles"}, n, 64);
    endtask

    initial begin
        int n;
        int seen;
        int nacc;
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            sz[d] = SZ_B; addr[d] = 8'h0; wd[d] = 32'h0;
        end

        repeat (3) @(negedge clk);
        chk("A reset req_ready", {31'b0, rdy[0]}, 32'h0);
        chk("A reset resp_valid", {31'b0, rv[0]}, 32'h0);
        chk("A reset resp_rdata", rd[0], 32'h0);
        chk("A reset init_done", {31'b0, idn[0]}, 32'h0);
        chk("B reset req_ready", {31'b0, rdy[1]}, 32'h0);
        chk("B reset init_done", {31'b0, idn[1]}, 32'h0);

        // DUT A: clear timing, then functional vectors.
        rst[0] = 1'b0;
        wait_clear("A", n, seen);
        issue(0, 0, SZ_W, 8'hFC, 32'h0, 32'h0000_0000, 0);
        issue(0, 1, SZ_W, 8'h10, 32'h1122_3344, 32'h0, 0);
        issue(0, 0, SZ_B, 8'h10, 32'h0, 32'h0000_0011, 0);
        issue(0, 0, SZ_B, 8'h11, 32'h0, 32'h0000_0022, 0);
        issue(0, 0, SZ_B, 8'h12, 32'h0, 32'h0000_0033, 0);
        issue(0, 0, SZ_B, 8'h13, 32'h0, 32'h0000_0044, 0);
        issue(0, 0, SZ_H, 8'h12, 32'h0, 32'h0000_3344, 0);
        issue(0, 0, SZ_H, 8'h10, 32'h0, 32'h0000_1122, 0);
        issue(0, 1, SZ_W, 8'h20, 32'hFFFF_FFFF, 32'h0, 0);
        issue(0, 1, SZ_B, 8'h21, 32'h1234_56AB, 32'h0, 0);
        issue(0, 0, SZ_W, 8'h20, 32'h0, 32'hFFAB_FFFF, 0);
        issue(0, 1, SZ_H, 8'h22, 32'h0000_BEEF, 32'h0, 0);
        issue(0, 0, SZ_W, 8'h20, 32'h0, 32'hFFAB_BEEF, 0);
        issue(0, 1, SZ_W, 8'h04, 32'h0102_0304, 32'h0, 0);
        issue(0, 1, SZ_W, 8'h08, 32'h0506_0708, 32'h0, 0);
        issue(0, 0, SZ_H, 8'h05, 32'h0, 32'h0, 1);
        issue(0, 1, SZ_W, 8'h06, 32'hCAFE_BABE, 32'h0, 1);
        issue(0, 1, SZ_R, 8'h08, 32'hDEAD_BEEF, 32'h0, 1);
        issue(0, 1, SZ_H, 8'h09, 32'h0000_9999, 32'h0, 1);
        issue(0, 0, SZ_W, 8'h04, 32'h0, 32'h0102_0304, 0);
        issue(0, 0, SZ_W, 8'h08, 32'h0, 32'h0506_0708, 0);
        issue(0, 1, SZ_W, 8'hFC, 32'hA5A5_5A5A, 32'h0, 0);
        issue(0, 0, SZ_W, 8'hFC, 32'h0, 32'hA5A5_5A5A, 0);

        // Continuous valid: one acceptance per LATENCY+1 cycles.
        vld[0] = 1'b1; wr[0] = 1'b0; sz[0] = SZ_W; addr[0] = 8'h10;
        nacc = 0;
        for (int k = 0; k < 16; k++) begin
            if (rdy[0]) begin
                nacc++;
                e.rdata = 32'h1122_3344; e.err = 1'b0; e.cyc = cyc + LAT_A;
                q0.push_back(e);
            end
            @(negedge clk);
        end
        vld[0] = 1'b0;
        chk("A stream_accepts", nacc, 4);
        drain();

        // Reset the cycle after a load is accepted: no response, array re-cleared.
        @(negedge clk);
        vld[0] = 1'b1; wr[0] = 1'b0; sz[0] = SZ_W; addr[0] = 8'h10;
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        rst[0] = 1'b1;
        seen = 0;
        @(negedge clk);
        if (rv[0]) seen++;
        @(negedge clk);
        if (rv[0]) seen++;
        rst[0] = 1'b0;
        wait_clear("A after reset", n, nacc);
        chk("A no_resp_after_reset", seen + nacc, 0);
        issue(0, 0, SZ_W, 8'h10, 32'h0, 32'h0000_0000, 0);
        issue(0, 0, SZ_W, 8'hFC, 32'h0, 32'h0000_0000, 0);

        // DUT B: no clear, LATENCY=1, stores survive reset.
        @(negedge clk);
        rst[1] = 1'b0;
        #1;
        chk("B init_done after release", {31'b0, idn[1]}, 32'h1);
        chk("B ready after release", {31'b0, rdy[1]}, 32'h1);
        issue(1, 1, SZ_W, 8'h30, 32'h1234_5678, 32'h0, 0);
        issue(1, 0, SZ_W, 8'h30, 32'h0, 32'h1234_5678, 0);
        @(negedge clk);
        vld[1] = 1'b1; wr[1] = 1'b1; sz[1] = SZ_W; addr[1] = 8'h30; wd[1] = 32'hFFFF_FFFF;
        rst[1] = 1'b1;
        @(negedge clk);
        vld[1] = 1'b0;
        rst[1] = 1'b0;
        issue(1, 0, SZ_W, 8'h30, 32'h0, 32'h1234_5678, 0);
        issue(1, 1, SZ_W, 8'h34, 32'h0BAD_F00D, 32'h0, 0);
        @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        issue(1, 0, SZ_W, 8'h34, 32'h0, 32'h0BAD_F00D, 0);
        issue(1, 0, SZ_B, 8'h37, 32'h0, 32'h0000_000D, 0);
        issue(1, 0, SZ_H, 8'h30, 32'h0, 32'h0000_1234, 0);

        drain();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised, multi-cycle data memory for the pipeline's MEM stage. It is byte-addressed and big-endian, with byte, half-word and word access sizes, and reports misaligned or reserved-size accesses as errors. Transfers use a valid/ready request channel and a one-cycle response strobe with programmable latency. An optional reset-time clear sequence zeroes the array, so no simulation `initial` preload is needed.

## Interface
- ADDR_W, 8, byte-address width; capacity = 2^ADDR_W bytes, ADDR_W >= 3
- LATENCY, 1, cycles from request acceptance to resp_valid; >= 1
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = contents undefined
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 reserved
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  load data, right-justified, zero-extended; 0 for stores and errors
- resp_error  out  1  misaligned or reserved-size request; qualified by resp_valid
- init_done  out  1  clear sequence finished; stays high until next reset

## Operation
- Storage is 2^(ADDR_W-2) words × 32 bits with four byte lanes.
- Byte offset 0 maps to bits [31:24] (big-endian). A word at address A holds {M[A], M[A+1], M[A+2], M[A+3]}.
- States:
  - CLEAR: writes zero to one word per cycle, index 0 .. 2^(ADDR_W-2)-1. After the last word it moves to IDLE and sets init_done. Skipped when CLEAR_ON_RESET=0.
  - IDLE: req_ready=1. Acceptance is req_valid && req_ready. It loads the latency counter with LATENCY-1 and moves to WAIT, or directly to RESP if LATENCY=1.
  - WAIT: counter decrements each cycle; moves to RESP when the counter reaches 0.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Errors:
  - Half access is misaligned when addr[0]=1; word access when addr[1:0]≠0; size 3 is reserved.
  - An error request is still accepted and responded to with resp_error=1 and resp_rdata=0. No write is performed.
- Stores:
  - Byte-lane write committed at the acceptance edge; unaffected lanes are preserved.
  - Byte store: wdata[7:0] goes to lane addr[1:0].
  - Half store: wdata[15:8] goes to M[A] and wdata[7:0] goes to M[A+1].
- Loads:
  - Array read at the acceptance edge and held in a response register until RESP.
  - A load accepted after a store's acceptance returns the stored data.
- Aligned accesses never wrap the address space; the top word (address 2^ADDR_W-4) is legal.

## Timing
- Reset values:
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_error=0.
  - init_done=0; state = CLEAR if CLEAR_ON_RESET=1, else IDLE. With CLEAR_ON_RESET=0, init_done=1 and req_ready=1 from the first cycle after reset deasserts.
- Clear duration is 2^(ADDR_W-2) cycles (64 for ADDR_W=8). req_ready=0 throughout.
- Response latency: accepted in cycle T, resp_valid high in cycle T+LATENCY.
- req_ready=0 from T+1 through T+LATENCY; next acceptance is possible at T+LATENCY+1. Throughput is one request per LATENCY+1 cycles.
- Request inputs are sampled only at acceptance and may change afterwards.
- resp_rdata and resp_error are stable while resp_valid=1, and return to 0 the cycle after.
- Reset asserted mid-operation:
  - The in-flight response is dropped; resp_valid=0 in the next cycle.
  - A store already committed at acceptance remains unless re-cleared.
  - Reset during CLEAR restarts the clear at index 0.
- Reset asserted in the same cycle as req_valid: the request is not accepted and no write occurs.

## Structure
- Package dm_pkg holds:
  - size encodings SIZE_BYTE=2'd0, SIZE_HALF=2'd1, SIZE_WORD=2'd2
  - state enum {CLEAR, IDLE, WAIT, RESP}
  - the function computing lane enables and misalignment from size and addr[1:0]
- Sub-module dm_byte_ram: word RAM with 4 byte-enables, synchronous write, and read captured on the same edge. Parameter WORDS.
- The top holds the FSM, latency counter, clear index, store-lane steering and load extraction/zero-extension.

## Test plan
- CLEAR_ON_RESET=1, ADDR_W=8: release reset -> init_done rises after exactly 64 cycles; a word load at 0xFC then returns 0x00000000.
- Word store 0x11223344 @0x10, then byte loads @0x10..0x13 -> 0x11, 0x22, 0x33, 0x44. Half load @0x12 -> 0x00003344.
- Byte store 0xAB @0x21 over word 0xFFFFFFFF -> word load @0x20 returns 0xFFABFFFF.
- Half load @0x05, word store @0x06, size 3 @0x08 -> each gives resp_error=1 and resp_rdata=0; memory at 0x04..0x0B is unchanged.
- LATENCY=3: accept at cycle T -> resp_valid high only at T+3, and req_ready low at T+1..T+3. Back-to-back valid stream -> one acceptance every 4 cycles.
- Reset in the cycle after a load is accepted -> no resp_valid. A store accepted before reset: with CLEAR_ON_RESET=0 it is readable after reset; with CLEAR_ON_RESET=1 it reads 0.
